// File: rtl/llc_req_sched.sv
// Multi-channel LLC front-end scheduler: per-channel request FIFOs, in-flight set blocking,
// priority-mask plus round-robin grant. Optional stall counters under LLC_SCHED_STATS_EN.
module llc_req_sched #(
    parameter int unsigned          NUM_CH       = 4,
    parameter int unsigned          ADDR_W       = 26,
    parameter int unsigned          SET_LSB      = 0,
    parameter int unsigned          SET_W        = 9,
    parameter int unsigned          FIFO_DEPTH   = 2,
    parameter int unsigned          MAX_INFLIGHT = 4,
    parameter logic [NUM_CH-1:0]    PRIO_MASK    = {{(NUM_CH-1){1'b0}}, 1'b1}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               req_valid,
    output logic [NUM_CH-1:0]               req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]        req_addr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ADDR_W-1:0]               out_addr,
    output logic [$clog2(NUM_CH)-1:0]       out_ch,
    output logic [$clog2(MAX_INFLIGHT)-1:0] out_slot,
    input  logic                            done_valid,
    input  logic [$clog2(MAX_INFLIGHT)-1:0] done_slot
`ifdef LLC_SCHED_STATS_EN
    ,
    input  logic                            stats_clr,
    output logic [NUM_CH*16-1:0]            stall_cnt
`endif
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned SLOT_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                  state_q;
    logic [CH_W-1:0]         rr_ptr_q;

    logic [ADDR_W-1:0]       fifo_mem_q [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q   [NUM_CH];
    logic [PTR_W-1:0]        rd_ptr_q   [NUM_CH];
    logic [CNT_W-1:0]        cnt_q      [NUM_CH];

    logic [MAX_INFLIGHT-1:0] tbl_valid_q;
    logic [SET_W-1:0]        tbl_set_q  [MAX_INFLIGHT];

    logic [ADDR_W-1:0]       head_addr  [NUM_CH];
    logic [SET_W-1:0]        head_set   [NUM_CH];
    logic [NUM_CH-1:0]       nonempty;
    logic [NUM_CH-1:0]       conflict;
    logic [NUM_CH-1:0]       elig;
    logic [NUM_CH-1:0]       push;
    logic [NUM_CH-1:0]       pop;
    logic                    tbl_full;
    logic [SLOT_W-1:0]       free_slot;
    logic [CH_W-1:0]         win_ch;
    logic                    accept;

    assign accept   = (state_q == StGrant) && out_ready;
    assign tbl_full = &tbl_valid_q;

    // Ready is taken from the registered count only; a same-cycle pop does not free a slot.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]      = req_valid[i] && req_ready[i];
            pop[i]       = accept && (out_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // In-flight table: done and an accept on a different slot may land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_valid_q <= '0;
        end else begin
            if (done_valid) tbl_valid_q[done_slot] <= 1'b0;
            if (accept)     tbl_valid_q[out_slot]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tbl_set_q[out_slot] <= out_addr[SET_LSB +: SET_W];
    end

    // The latched grant counts as an in-flight set for every other channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            head_addr[i] = fifo_mem_q[i][rd_ptr_q[i]];
            head_set[i]  = head_addr[i][SET_LSB +: SET_W];
            nonempty[i]  = (cnt_q[i] != '0);
            conflict[i]  = (state_q == StGrant) && (out_ch != CH_W'(i)) &&
                           (out_addr[SET_LSB +: SET_W] == head_set[i]);
            for (int j = 0; j < MAX_INFLIGHT; j++) begin
                if (tbl_valid_q[j] && (tbl_set_q[j] == head_set[i])) conflict[i] = 1'b1;
            end
            elig[i] = nonempty[i] && !conflict[i] && !tbl_full;
        end
    end

    always_comb begin
        logic found;
        found     = 1'b0;
        free_slot = '0;
        for (int j = 0; j < MAX_INFLIGHT; j++) begin
            if (!found && !tbl_valid_q[j]) begin
                free_slot = SLOT_W'(j);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        logic        found;
        int unsigned idx;
        found  = 1'b0;
        idx    = 0;
        win_ch = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && elig[i] && PRIO_MASK[i]) begin
                win_ch = CH_W'(i);
                found  = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_CH;
            if (!found && elig[idx]) begin
                win_ch = CH_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_ch    <= '0;
            out_slot  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|elig) begin
                        out_valid <= 1'b1;
                        out_addr  <= head_addr[win_ch];
                        out_ch    <= win_ch;
                        out_slot  <= free_slot;
                        state_q   <= StGrant;
                    end
                end
                StGrant: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                        if (!PRIO_MASK[out_ch]) begin
                            rr_ptr_q <= (out_ch == CH_W'(NUM_CH - 1)) ? '0 : out_ch + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LLC_SCHED_STATS_EN
    logic [15:0] stall_q [NUM_CH];

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) stall_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stats_clr) begin
                    stall_q[i] <= '0;
                end else if (nonempty[i] && conflict[i] && (stall_q[i] != 16'hFFFF)) begin
                    stall_q[i] <= stall_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) stall_cnt[i*16 +: 16] = stall_q[i];
    end
`endif

endmodule

// File: tb/tb_llc_req_sched.sv
// Directed self-checking bench for llc_req_sched with default parameters.
module tb_llc_req_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [103:0] req_addr;
    logic         out_valid;
    logic         out_ready;
    logic [25:0]  out_addr;
    logic [1:0]   out_ch;
    logic [1:0]   out_slot;
    logic         done_valid;
    logic [1:0]   done_slot;
`ifdef LLC_SCHED_STATS_EN
    logic         stats_clr;
    logic [63:0]  stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    llc_req_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_ch     (out_ch),
        .out_slot   (out_slot),
        .done_valid (done_valid),
        .done_slot  (done_slot)
`ifdef LLC_SCHED_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [25:0] a);
        req_valid[ch]           = 1'b1;
        req_addr[ch*26 +: 26]   = a;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        out_ready  = 1'b0;
        done_valid = 1'b0;
        done_slot  = '0;
`ifdef LLC_SCHED_STATS_EN
        stats_clr  = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] ch, input logic [25:0] a,
                                input logic [1:0] slot);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ch"},    32'(out_ch),    32'(ch));
        check({tag, "_addr"},  32'(out_addr),  32'(a));
        check({tag, "_slot"},  32'(out_slot),  32'(slot));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        // Reset values, sampled while reset is held.
        rst        = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        out_ready  = 1'b0;
        done_valid = 1'b0;
        done_slot  = '0;
`ifdef LLC_SCHED_STATS_EN
        stats_clr  = 1'b0;
`endif
        tick();
        check("rst_ready", 32'(req_ready), 32'hF);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr",  32'(out_addr),  32'd0);
        check("rst_ch",    32'(out_ch),    32'd0);
        check("rst_slot",  32'(out_slot),  32'd0);
        rst = 1'b0;

        // Single request on ch1: one cycle from push to grant.
        set_req(1, 26'h123);
        tick();
        req_valid = '0;
        check("t1_nolat", 32'(out_valid), 32'd0);
        tick();
        expect_grant("t1", 2'd1, 26'h123, 2'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_accept", 32'(out_valid), 32'd0);
        done_valid = 1'b1;
        done_slot  = 2'd0;
        tick();
        done_valid = 1'b0;

        // ch0 (priority) and ch2 share set 0x045; ch2 waits for done.
        set_req(0, 26'h045);
        set_req(2, 26'h245);
        tick();
        req_valid = '0;
        tick();
        expect_grant("t2_ch0", 2'd0, 26'h045, 2'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_blocked", 32'(out_valid), 32'd0);
            tick();
        end
        done_valid = 1'b1;
        done_slot  = 2'd0;
        tick();
        done_valid = 1'b0;
        check("t2_done_edge", 32'(out_valid), 32'd0);
        tick();
        expect_grant("t2_ch2", 2'd2, 26'h245, 2'd0);

        // Round-robin order 1,2,3 then table-full stall.
        do_reset();
        out_ready = 1'b1;
        set_req(1, 26'h011);
        set_req(2, 26'h022);
        set_req(3, 26'h033);
        tick();
        req_valid = '0;
        check("t3_nolat", 32'(out_valid), 32'd0);
        tick();
        expect_grant("t3_g1", 2'd1, 26'h011, 2'd0);
        tick();
        check("t3_gap1", 32'(out_valid), 32'd0);
        tick();
        expect_grant("t3_g2", 2'd2, 26'h022, 2'd1);
        tick();
        tick();
        expect_grant("t3_g3", 2'd3, 26'h033, 2'd2);
        // rr_ptr wraps to 0, so ch1 beats ch3.
        set_req(1, 26'h044);
        set_req(3, 26'h055);
        tick();
        req_valid = '0;
        tick();
        expect_grant("t3_rrwrap", 2'd1, 26'h044, 2'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_full", 32'(out_valid), 32'd0);
            tick();
        end
        done_valid = 1'b1;
        done_slot  = 2'd1;
        tick();
        done_valid = 1'b0;
        check("t4_done_edge", 32'(out_valid), 32'd0);
        tick();
        expect_grant("t4_freed", 2'd3, 26'h055, 2'd1);
        tick();

        // Stalled grant holds outputs; ch2 buffer fills to 2.
        do_reset();
        set_req(2, 26'h100);
        tick();
        set_req(2, 26'h101);
        tick();
        expect_grant("t5_hold", 2'd2, 26'h100, 2'd0);
        check("t5_full", 32'(req_ready), 32'hB);
        set_req(2, 26'h102);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_stable_addr", 32'(out_addr), 32'h100);
            check("t5_nopop", 32'(req_ready), 32'hB);
        end
        check("t5_stable_ch",   32'(out_ch),   32'd2);
        check("t5_stable_slot", 32'(out_slot), 32'd0);
        out_ready = 1'b1;
        tick();
        req_valid = '0;
        out_ready = 1'b0;
        check("t5_accept", 32'(out_valid), 32'd0);
        check("t5_popped", 32'(req_ready), 32'hF);
        tick();
        expect_grant("t5_second", 2'd2, 26'h101, 2'd1);

`ifdef LLC_SCHED_STATS_EN
        // Stall counters: 10 conflict cycles, clear, then saturation.
        do_reset();
        out_ready = 1'b1;
        set_req(0, 26'h007);
        tick();
        req_valid = '0;
        tick();
        tick();
        out_ready = 1'b0;
        set_req(1, 26'h207);
        tick();
        req_valid = '0;
        repeat (10) tick();
        check("st_cnt10", 32'(stall_cnt[31:16]), 32'd10);
        check("st_ch0",   32'(stall_cnt[15:0]),  32'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("st_clr", 32'(stall_cnt[31:16]), 32'd0);
        repeat (70000) tick();
        check("st_sat", 32'(stall_cnt[31:16]), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
